// File: rtl/dice_pkg.sv
// Shared definitions for the dice roller: state encoding, face range, face wrap helper.
package dice_pkg;

   localparam int unsigned FACE_W = 3;
   localparam int unsigned VALUE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      SPIN = 2'd2
   } state_e;

   localparam logic [FACE_W-1:0] FACE_MIN = FACE_W'(1);
   localparam logic [FACE_W-1:0] FACE_MAX = FACE_W'(6);

   // Next face value with 6 -> 1 wrap; anything out of range also returns to 1.
   function automatic logic [FACE_W-1:0] face_next(input logic [FACE_W-1:0] v);
      return (v >= FACE_MAX || v < FACE_MIN) ? FACE_MIN : FACE_W'(v + FACE_W'(1));
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, press/release strobes.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic level,
   output logic press,
   output logic release_stb
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      (DEBOUNCE_CYCLES > 1) ? CNT_W'(DEBOUNCE_CYCLES - 1) : '0;

   logic [1:0]       sync_q, sync_d;
   logic             level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q, press_d;
   logic             rel_q, rel_d;
   logic             key_lvl_c;

   // Synchronise, then toggle the accepted level after a full run of disagreement.
   always_comb begin
      sync_d    = {sync_q[0], key_n};
      key_lvl_c = ~sync_q[1];
      level_d   = level_q;
      cnt_d     = '0;
      press_d   = 1'b0;
      rel_d     = 1'b0;
      if (key_lvl_c != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = key_lvl_c;
            press_d = key_lvl_c;
            rel_d   = ~key_lvl_c;
         end else begin
            cnt_d = CNT_W'(cnt_q + CNT_W'(1));
         end
      end
   end

   // Register stage; synchroniser resets to the released (high) key level.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= 2'b11;
         level_q <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
         rel_q   <= rel_d;
      end
   end

   assign level       = level_q;
   assign press       = press_q;
   assign release_stb = rel_q;

endmodule

// File: rtl/dice_roller.sv
// Push-button die: debounced key, free-running face counter, animated hold/spin, registered result.
module dice_roller
   import dice_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned TICK_CYCLES     = 2500000,
   parameter int unsigned SPIN_STEPS      = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               key_n,
   input  logic               enable,
   output logic [VALUE_W-1:0] value,
   output logic               busy,
   output logic               done
);

   localparam int unsigned SPIN_EFF = (SPIN_STEPS == 0) ? 1 : SPIN_STEPS;
   localparam int unsigned SPIN_W   = $clog2(SPIN_EFF + 1);
   localparam int unsigned TICK_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST =
      (TICK_CYCLES > 1) ? TICK_W'(TICK_CYCLES - 1) : '0;
   localparam logic [SPIN_W-1:0] SPIN_INIT = SPIN_W'(SPIN_EFF);

   logic                key_level, press, release_stb;
   logic                hold_end_c, tick_c;
   state_e              state_q, state_d;
   logic [FACE_W-1:0]   face_q, face_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   logic [VALUE_W-1:0]  value_q, value_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [FACE_W-1:0]   result_q, result_d;
   logic [SPIN_W-1:0]   spin_q, spin_d;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk         (clk),
      .rst         (rst),
      .key_n       (key_n),
      .level       (key_level),
      .press       (press),
      .release_stb (release_stb)
   );

   // Hold ends on the release strobe; the debounced level drops in that same cycle.
   assign hold_end_c = release_stb | ~key_level;

   // Face counter and animation tick; tick restarts its phase on HOLD entry only.
   always_comb begin
      face_d = face_next(face_q);
      tick_c = (tick_q == TICK_LAST);
      tick_d = tick_c ? '0 : TICK_W'(tick_q + TICK_W'(1));
      if (state_q == IDLE && state_d == HOLD) begin
         tick_d = '0;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (press && enable) state_d = HOLD;
         HOLD:    if (hold_end_c) state_d = SPIN;
         SPIN:    if (tick_c && spin_q == SPIN_W'(1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath next values.
   always_comb begin
      value_d  = value_q;
      done_d   = 1'b0;
      result_d = result_q;
      spin_d   = spin_q;
      busy_d   = (state_d == HOLD) || (state_d == SPIN);
      unique case (state_q)
         IDLE: begin
            if (press && enable) value_d = VALUE_W'(FACE_MIN);
         end
         HOLD: begin
            if (tick_c) value_d = {1'b0, face_next(value_q[FACE_W-1:0])};
            if (hold_end_c) begin
               result_d = face_q;
               spin_d   = SPIN_INIT;
            end
         end
         SPIN: begin
            if (tick_c) begin
               if (spin_q == SPIN_W'(1)) begin
                  value_d = {1'b0, result_q};
                  done_d  = 1'b1;
               end else begin
                  value_d = {1'b0, face_next(value_q[FACE_W-1:0])};
               end
               spin_d = SPIN_W'(spin_q - SPIN_W'(1));
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         face_q   <= FACE_MIN;
         tick_q   <= '0;
         value_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         spin_q   <= '0;
      end else begin
         face_q   <= face_d;
         tick_q   <= tick_d;
         value_q  <= value_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         spin_q   <= spin_d;
      end
   end

   assign value = value_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_dice_roller.sv
// Bench for dice_roller: random rolls checked cycle-by-cycle against a timing/arithmetic model.
module tb_dice_roller;

   localparam int unsigned D = 4;
   localparam int unsigned T = 3;
   localparam int unsigned S = 2;
   localparam int S_EFF = (S == 0) ? 1 : int'(S);

   logic       clk;
   logic       rst;
   logic       key_n;
   logic       enable;
   logic [3:0] value;
   logic       busy;
   logic       done;

   int n;          // clock edges since the last edge that saw rst=1
   int n_asrt;
   int n_fail;
   int last_val;

   dice_roller #(
      .DEBOUNCE_CYCLES (D),
      .TICK_CYCLES     (T),
      .SPIN_STEPS      (S)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .key_n  (key_n),
      .enable (enable),
      .value  (value),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, n, obs, exp);
      end
   endtask

   task automatic step();
      logic r_seen;
      r_seen = rst;
      @(posedge clk);
      #1;
      if (r_seen) n = 0;
      else n++;
   endtask

   task automatic chk_outs(input string tag, input int ev, input int eb, input int ed);
      chk({tag, ".value"}, 32'(value), ev);
      chk({tag, ".busy"},  32'(busy),  eb);
      chk({tag, ".done"},  32'(done),  ed);
   endtask

   // One roll: key low for len cycles. Expected behaviour from the timing rules:
   // strobe = raw edge + D + 2, HOLD at press+1, value = 1 + (cycles in HOLD / T) mod 6,
   // done on the S-th tick strictly after SPIN entry, result = face at release strobe.
   task automatic roll(input int len, input bit en, input bit drop,
                       input bit repress, input bit do_rst);
      int e1, e2, h, r, m0, dn, res, ev, eb, ed;
      bit low;
      e1 = n;
      e2 = e1 + len;
      h  = e1 + int'(D) + 3;
      r  = e2 + int'(D) + 2;
      m0 = (r + 2 - h + int'(T) - 1) / int'(T);
      if (m0 < 1) m0 = 1;
      dn  = h + (m0 + S_EFF - 1) * int'(T);
      res = (r % 6) + 1;
      enable = en;
      key_n  = 1'b0;
      while (n < e2 + 30) begin
         step();
         low   = (n < e2) || (repress && n >= e2 + 4 && n < e2 + 14);
         key_n = ~low;
         if (en && drop && n == h + 1) enable = 1'b0;
         if (!en || n < h) begin
            ev = last_val; eb = 0; ed = 0;
         end else if (n < dn) begin
            ev = ((n - h) / int'(T)) % 6 + 1; eb = 1; ed = 0;
         end else begin
            ev = res; eb = 0; ed = (n == dn) ? 1 : 0;
         end
         chk_outs(en ? "roll" : "disabled", ev, eb, ed);
         if (do_rst && en && n == r + 2) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            chk_outs("rst_mid_spin", 0, 0, 0);
            last_val = 0;
            repeat (20) begin
               step();
               chk_outs("after_rst", 0, 0, 0);
            end
            return;
         end
      end
      if (en) last_val = res;
   endtask

   initial begin
      n        = 0;
      n_asrt   = 0;
      n_fail   = 0;
      last_val = 0;
      rst      = 1'b1;
      key_n    = 1'b1;
      enable   = 1'b1;

      // Reset held for three cycles.
      repeat (3) step();
      rst = 1'b0;
      chk_outs("reset", 0, 0, 0);
      chk("reset.face", 32'(dut.face_q), 1);
      repeat (4) begin
         step();
         chk_outs("idle", 0, 0, 0);
      end

      // Bounce shorter than the debounce window.
      key_n = 1'b0;
      repeat (3) step();
      key_n = 1'b1;
      repeat (15) begin
         step();
         chk_outs("bounce", last_val, 0, 0);
      end

      // Directed full roll, then a disabled roll.
      roll(20, 1'b1, 1'b0, 1'b0, 1'b0);
      roll(12, 1'b0, 1'b0, 1'b0, 1'b0);

      // Random rolls: random hold length, enable, enable dropping mid-roll.
      for (int i = 0; i < 10; i++) begin
         roll(int'($urandom_range(8, 30)), ($urandom_range(0, 3) != 0),
              bit'($urandom_range(0, 1)), 1'b0, 1'b0);
      end

      // Second press while spinning is ignored.
      roll(int'($urandom_range(10, 25)), 1'b1, 1'b0, 1'b1, 1'b0);

      // Reset two cycles into SPIN, then a clean roll afterwards.
      roll(20, 1'b1, 1'b0, 1'b0, 1'b1);
      roll(int'($urandom_range(8, 30)), 1'b1, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
